ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage directly downstream of the ALU. Consumes the ALU result and its zero/slt/sltu flags, resolves conditional branches and jumps, and selects the writeback value (ALU result or link address). Registers the selected value with control fields into a 2-entry skid buffer under valid/ready handshakes, and issues a one-cycle front-end redirect for taken control transfers.

## Interface
- DATA_WIDTH, 64, datapath width
- REG_ADDR_WIDTH, 5, destination register index width
- clk  in  1  clock, rising edge
- arst  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream holds a valid execute bundle
- o_ready  out  1  stage can accept this cycle
- i_alu_result  in  DATA_WIDTH  ALU result
- i_zero_flag, i_slt_flag, i_sltu_flag  in  1 each  ALU flags for the same operation
- i_branch  in  1  conditional branch
- i_jump  in  1  unconditional jump (JAL/JALR)
- i_func3  in  3  branch condition code
- i_pc_target  in  DATA_WIDTH  branch/jump target
- i_pc_plus4  in  DATA_WIDTH  link address
- i_link  in  1  writeback value is i_pc_plus4
- i_store_data  in  DATA_WIDTH  rs2 value for stores
- i_rd_addr  in  REG_ADDR_WIDTH  destination register
- i_reg_write, i_mem_write  in  1 each  control
- i_flush  in  1  discard all held and incoming bundles
- o_valid  out  1  output bundle valid
- i_ready  in  1  downstream accepts
- o_result, o_store_data  out  DATA_WIDTH  registered bundle data
- o_rd_addr  out  REG_ADDR_WIDTH; o_reg_write, o_mem_write  out  1 each
- o_redirect  out  1  one-cycle taken-transfer pulse
- o_redirect_pc  out  DATA_WIDTH  redirect target

## Operation
- Accept = i_valid & o_ready & !i_flush. Downstream transfer = o_valid & i_ready.
- Condition by i_func3: 000 zero; 001 !zero; 100 slt; 101 !slt; 110 sltu; 111 !sltu; 010/011 false.
- taken = i_jump | (i_branch & condition). Result = i_link ? i_pc_plus4 : i_alu_result.
- Redirect: on accept with taken, next cycle o_redirect=1, o_redirect_pc=i_pc_target; otherwise o_redirect=0. Issued independently of downstream stall.
- Skid FSM (main register M drives outputs, skid register S):
  - EMPTY: accept -> load M, go ONE.
  - ONE: accept & transfer -> load M, stay; accept & !transfer -> load S, go FULL; transfer only -> EMPTY.
  - FULL: o_ready=0; transfer -> M<=S, go ONE.
- o_ready = (state != FULL), from registered state only (no i_ready combinational path).
- i_flush: next edge -> EMPTY, o_valid=0, same-cycle input dropped, no redirect for it. Flush beats accept and transfer.
- Ordering strictly FIFO; no bundle duplicated or lost except by flush.

## Timing
- Reset (arst high, asynchronous): state EMPTY, o_valid=0, o_redirect=0, all data/control outputs 0; o_ready=1 once reset deasserts.
- Latency: accepted bundle visible on outputs one cycle later when M frees that cycle; throughput 1/cycle with i_ready held high.
- Redirect latency: exactly 1 cycle after accept, width exactly 1 cycle.
- Reset mid-operation: both entries and pending redirect discarded immediately.
- Output data held stable while o_valid & !i_ready.

## Structure
- Package ex_mem_pkg: t_skid_state enum (EMPTY, ONE, FULL), func3 branch constants (BEQ, BNE, BLT, BGE, BLTU, BGEU), packed struct t_ex_mem_bundle (result, store_data, rd_addr, reg_write, mem_write).
- One sub-module: branch_resolve (combinational, func3 + flags + i_branch/i_jump -> taken).

## Test plan
- Reset: assert arst mid-stream with FULL -> o_valid=0, o_redirect=0, o_ready=1 after release.
- Branch decode: func3=000, i_zero_flag=1, i_branch=1, target 0x1000 -> o_redirect=1 for one cycle, o_redirect_pc=0x1000; func3=001 same flags -> no redirect; func3=010 -> no redirect.
- Link: i_jump=1, i_link=1, i_pc_plus4=0x2004, i_alu_result=0x55 -> o_result=0x2004, redirect issued.
- Backpressure: i_ready=0, three bundles offered (results 1,2,3) -> 1 and 2 accepted, o_ready=0 after second; release i_ready -> outputs 1,2,3 in order, no loss.
- Flush: FULL with i_valid=1 and i_flush=1 -> next cycle o_valid=0, no redirect, state EMPTY.
- Streaming: 100 random bundles, random i_ready -> scoreboard matches in order; redirect count equals taken count.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the execute-to-memory stage.
package ex_mem_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int REG_ADDR_WIDTH = 5;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } t_skid_state;

    // Branch condition codes carried in func3.
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Everything that travels on to the memory stage.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      reg_write;
        logic                      mem_write;
    } t_ex_mem_bundle;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Upstream execute bundle, downstream memory bundle and redirect signals.
interface ex_mem_stage_if;
    import ex_mem_pkg::*;

    logic                      i_valid;
    logic                      o_ready;
    logic [DATA_WIDTH-1:0]     i_alu_result;
    logic                      i_zero_flag;
    logic                      i_slt_flag;
    logic                      i_sltu_flag;
    logic                      i_branch;
    logic                      i_jump;
    logic [2:0]                i_func3;
    logic [DATA_WIDTH-1:0]     i_pc_target;
    logic [DATA_WIDTH-1:0]     i_pc_plus4;
    logic                      i_link;
    logic [DATA_WIDTH-1:0]     i_store_data;
    logic [REG_ADDR_WIDTH-1:0] i_rd_addr;
    logic                      i_reg_write;
    logic                      i_mem_write;
    logic                      i_flush;
    logic                      o_valid;
    logic                      i_ready;
    logic [DATA_WIDTH-1:0]     o_result;
    logic [DATA_WIDTH-1:0]     o_store_data;
    logic [REG_ADDR_WIDTH-1:0] o_rd_addr;
    logic                      o_reg_write;
    logic                      o_mem_write;
    logic                      o_redirect;
    logic [DATA_WIDTH-1:0]     o_redirect_pc;

    // The stage itself.
    modport slave (
        input  i_valid, i_alu_result, i_zero_flag, i_slt_flag, i_sltu_flag,
               i_branch, i_jump, i_func3, i_pc_target, i_pc_plus4, i_link,
               i_store_data, i_rd_addr, i_reg_write, i_mem_write, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_store_data, o_rd_addr,
               o_reg_write, o_mem_write, o_redirect, o_redirect_pc
    );

    // The environment around the stage (pipeline neighbours or a bench).
    modport master (
        output i_valid, i_alu_result, i_zero_flag, i_slt_flag, i_sltu_flag,
               i_branch, i_jump, i_func3, i_pc_target, i_pc_plus4, i_link,
               i_store_data, i_rd_addr, i_reg_write, i_mem_write, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_store_data, o_rd_addr,
               o_reg_write, o_mem_write, o_redirect, o_redirect_pc
    );

endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Decides whether a control transfer is taken from func3 and the ALU flags.
module branch_resolve
    import ex_mem_pkg::*;
(
    input  logic       i_branch,
    input  logic       i_jump,
    input  logic [2:0] i_func3,
    input  logic       i_zero_flag,
    input  logic       i_slt_flag,
    input  logic       i_sltu_flag,
    output logic       o_taken
);

    logic w_cond;

    // Map the condition code onto the matching flag; reserved codes never branch.
    always_comb begin
        w_cond = 1'b0;
        case (i_func3)
            BEQ:     w_cond = i_zero_flag;
            BNE:     w_cond = ~i_zero_flag;
            BLT:     w_cond = i_slt_flag;
            BGE:     w_cond = ~i_slt_flag;
            BLTU:    w_cond = i_sltu_flag;
            BGEU:    w_cond = ~i_sltu_flag;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_taken = i_jump | (i_branch & w_cond);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: resolves branches, picks the writeback value and
// holds bundles in a two-entry skid buffer so o_ready never depends on i_ready.
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic          clk,
    input  logic          arst,
    ex_mem_stage_if.slave bus
);

    t_skid_state    r_state;
    t_skid_state    w_state_next;
    t_ex_mem_bundle r_main;
    t_ex_mem_bundle r_skid;
    t_ex_mem_bundle w_in_bundle;
    logic           r_redirect;
    logic [DATA_WIDTH-1:0] r_redirect_pc;

    logic w_ready;
    logic w_valid;
    logic w_accept;
    logic w_xfer;
    logic w_taken;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    branch_resolve u_branch_resolve (
        .i_branch    (bus.i_branch),
        .i_jump      (bus.i_jump),
        .i_func3     (bus.i_func3),
        .i_zero_flag (bus.i_zero_flag),
        .i_slt_flag  (bus.i_slt_flag),
        .i_sltu_flag (bus.i_sltu_flag),
        .o_taken     (w_taken)
    );

    assign w_in_bundle = '{
        result:     bus.i_link ? bus.i_pc_plus4 : bus.i_alu_result,
        store_data: bus.i_store_data,
        rd_addr:    bus.i_rd_addr,
        reg_write:  bus.i_reg_write,
        mem_write:  bus.i_mem_write
    };

    // Ready and valid come straight from the registered state.
    assign w_ready  = (r_state != FULL);
    assign w_valid  = (r_state != EMPTY);
    assign w_accept = bus.i_valid & w_ready & ~bus.i_flush;
    assign w_xfer   = w_valid & bus.i_ready;

    // Next occupancy and which register loads; flush overrides everything.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.i_flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_state_next = FULL;
                    end else if (w_xfer) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_xfer) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ONE;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= EMPTY;
        else      r_state <= w_state_next;
    end

    // Main and skid data registers; main always feeds the outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in)        r_main <= w_in_bundle;
            else if (w_load_main_skid) r_main <= r_skid;
            if (w_load_skid)           r_skid <= w_in_bundle;
        end
    end

    // One-cycle redirect pulse for every accepted taken transfer, regardless of stall.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_accept & w_taken;
            if (w_accept && w_taken) r_redirect_pc <= bus.i_pc_target;
        end
    end

    assign bus.o_ready       = w_ready;
    assign bus.o_valid       = w_valid;
    assign bus.o_result      = r_main.result;
    assign bus.o_store_data  = r_main.store_data;
    assign bus.o_rd_addr     = r_main.rd_addr;
    assign bus.o_reg_write   = r_main.reg_write;
    assign bus.o_mem_write   = r_main.mem_write;
    assign bus.o_redirect    = r_redirect;
    assign bus.o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios then random streaming, checked
// against a capacity-2 queue model of the stage.
module tb_ex_mem_stage;
    import ex_mem_pkg::*;

    logic clk = 1'b0;
    logic arst;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    t_ex_mem_bundle q[$];
    logic [63:0]    drained[$];
    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int exp_redir_cnt = 0;
    int obs_redir_cnt = 0;

    function automatic logic ref_taken(logic jump, logic branch, logic [2:0] f3,
                                       logic z, logic lt, logic ltu);
        logic c;
        c = 1'b0;
        if (f3 == 3'd0) c = z;
        if (f3 == 3'd1) c = !z;
        if (f3 == 3'd4) c = lt;
        if (f3 == 3'd5) c = !lt;
        if (f3 == 3'd6) c = ltu;
        if (f3 == 3'd7) c = !ltu;
        return jump || (branch && c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs(input logic rdy);
        bus.i_valid      = 1'b0;
        bus.i_alu_result = '0;
        bus.i_zero_flag  = 1'b0;
        bus.i_slt_flag   = 1'b0;
        bus.i_sltu_flag  = 1'b0;
        bus.i_branch     = 1'b0;
        bus.i_jump       = 1'b0;
        bus.i_func3      = 3'd0;
        bus.i_pc_target  = '0;
        bus.i_pc_plus4   = '0;
        bus.i_link       = 1'b0;
        bus.i_store_data = '0;
        bus.i_rd_addr    = '0;
        bus.i_reg_write  = 1'b0;
        bus.i_mem_write  = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_ready      = rdy;
    endtask

    task automatic rand_bundle();
        bus.i_alu_result = {$urandom, $urandom};
        bus.i_zero_flag  = 1'($urandom);
        bus.i_slt_flag   = 1'($urandom);
        bus.i_sltu_flag  = 1'($urandom);
        bus.i_branch     = 1'($urandom);
        bus.i_jump       = ($urandom_range(0, 3) == 0);
        bus.i_func3      = 3'($urandom);
        bus.i_pc_target  = {$urandom, $urandom};
        bus.i_pc_plus4   = {$urandom, $urandom};
        bus.i_link       = bus.i_jump & 1'($urandom);
        bus.i_store_data = {$urandom, $urandom};
        bus.i_rd_addr    = 5'($urandom);
        bus.i_reg_write  = 1'($urandom);
        bus.i_mem_write  = 1'($urandom);
    endtask

    task automatic check_outputs();
        chk("o_valid", 64'(bus.o_valid), 64'(q.size() > 0));
        chk("o_ready", 64'(bus.o_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("o_result", bus.o_result, q[0].result);
            chk("o_store_data", bus.o_store_data, q[0].store_data);
            chk("o_rd_addr", 64'(bus.o_rd_addr), 64'(q[0].rd_addr));
            chk("o_reg_write", 64'(bus.o_reg_write), 64'(q[0].reg_write));
            chk("o_mem_write", 64'(bus.o_mem_write), 64'(q[0].mem_write));
        end
    endtask

    // One clock: check outputs, predict, clock, update model, check redirect.
    task automatic cycle();
        logic acc, xf, tk;
        logic [63:0] tgt;
        t_ex_mem_bundle nb;
        check_outputs();
        acc = bus.i_valid && (q.size() < 2) && !bus.i_flush;
        xf  = (q.size() > 0) && bus.i_ready;
        tk  = ref_taken(bus.i_jump, bus.i_branch, bus.i_func3,
                        bus.i_zero_flag, bus.i_slt_flag, bus.i_sltu_flag);
        tgt = bus.i_pc_target;
        nb.result     = bus.i_link ? bus.i_pc_plus4 : bus.i_alu_result;
        nb.store_data = bus.i_store_data;
        nb.rd_addr    = bus.i_rd_addr;
        nb.reg_write  = bus.i_reg_write;
        nb.mem_write  = bus.i_mem_write;
        @(posedge clk);
        #1;
        if (bus.i_flush) begin
            q.delete();
        end else begin
            if (xf) begin
                $display("xfer result=%h rd=%0d", q[0].result, q[0].rd_addr);
                drained.push_back(q[0].result);
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(nb);
                acc_cnt++;
            end
        end
        chk("o_redirect", 64'(bus.o_redirect), 64'(acc && tk));
        if (acc && tk) begin
            chk("o_redirect_pc", bus.o_redirect_pc, tgt);
            exp_redir_cnt++;
        end
        if (bus.o_redirect) obs_redir_cnt++;
    endtask

    initial begin
        // Reset state
        arst = 1'b1;
        idle_inputs(1'b1);
        #12;
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_redirect", 64'(bus.o_redirect), 64'd0);
        chk("rst_o_result", bus.o_result, 64'd0);
        chk("rst_o_store_data", bus.o_store_data, 64'd0);
        chk("rst_o_rd_addr", 64'(bus.o_rd_addr), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_o_ready", 64'(bus.o_ready), 64'd1);

        // Branch decode: BEQ taken, BNE and reserved code not taken
        for (int f = 0; f < 3; f++) begin
            idle_inputs(1'b1);
            bus.i_valid     = 1'b1;
            bus.i_branch    = 1'b1;
            bus.i_zero_flag = 1'b1;
            bus.i_func3     = 3'(f);
            bus.i_pc_target = 64'h1000;
            bus.i_alu_result = 64'(f + 16);
            cycle();
            if (f == 0) chk("beq_redirect", 64'(bus.o_redirect), 64'd1);
            else        chk("nt_redirect", 64'(bus.o_redirect), 64'd0);
            idle_inputs(1'b1);
            cycle();
            chk("redirect_width", 64'(bus.o_redirect), 64'd0);
        end

        // Link writeback on a jump
        idle_inputs(1'b1);
        bus.i_valid      = 1'b1;
        bus.i_jump       = 1'b1;
        bus.i_link       = 1'b1;
        bus.i_pc_plus4   = 64'h2004;
        bus.i_alu_result = 64'h55;
        bus.i_pc_target  = 64'h3000;
        cycle();
        chk("link_result", bus.o_result, 64'h2004);
        chk("link_redirect", 64'(bus.o_redirect), 64'd1);
        idle_inputs(1'b1);
        cycle();

        // Backpressure: three offered with i_ready low, then drain
        drained.delete();
        for (int k = 1; k <= 3; k++) begin
            idle_inputs(1'b0);
            bus.i_valid      = 1'b1;
            bus.i_alu_result = 64'(k);
            bus.i_rd_addr    = 5'(k);
            cycle();
        end
        chk("bp_full_ready", 64'(bus.o_ready), 64'd0);
        bus.i_ready = 1'b1;
        cycle();
        cycle();
        idle_inputs(1'b1);
        cycle();
        cycle();
        chk("bp_drain_count", 64'(drained.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < drained.size()) chk("bp_order", drained[k], 64'(k + 1));
        end

        // Flush while FULL with a taken bundle offered
        for (int k = 0; k < 2; k++) begin
            idle_inputs(1'b0);
            rand_bundle();
            bus.i_valid = 1'b1;
            cycle();
        end
        idle_inputs(1'b0);
        bus.i_valid     = 1'b1;
        bus.i_jump      = 1'b1;
        bus.i_pc_target = 64'h4000;
        bus.i_flush     = 1'b1;
        cycle();
        chk("flush_o_valid", 64'(bus.o_valid), 64'd0);
        chk("flush_o_ready", 64'(bus.o_ready), 64'd1);
        chk("flush_redirect", 64'(bus.o_redirect), 64'd0);
        idle_inputs(1'b1);
        cycle();

        // Asynchronous reset while FULL with a redirect pending
        for (int k = 0; k < 2; k++) begin
            idle_inputs(1'b0);
            rand_bundle();
            bus.i_valid  = 1'b1;
            bus.i_jump   = 1'b1;
            cycle();
        end
        #1;
        arst = 1'b1;
        #1;
        chk("mid_rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("mid_rst_o_redirect", 64'(bus.o_redirect), 64'd0);
        q.delete();
        idle_inputs(1'b1);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_o_ready", 64'(bus.o_ready), 64'd1);
        cycle();

        // Random streaming of 100 bundles
        acc_cnt = 0;
        exp_redir_cnt = 0;
        obs_redir_cnt = 0;
        for (int n = 0; n < 3000 && acc_cnt < 100; n++) begin
            idle_inputs(1'($urandom));
            rand_bundle();
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_flush = ($urandom_range(0, 39) == 0);
            cycle();
        end
        chk("stream_accepts", 64'(acc_cnt >= 100), 64'd1);
        idle_inputs(1'b1);
        for (int n = 0; n < 4; n++) cycle();
        chk("stream_redirects", 64'(obs_redir_cnt), 64'(exp_redir_cnt));
        chk("stream_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
